// File: rtl/lu_pkg.sv
// Shared types and sizing helpers for the LU trailing-update cell.
// Pure declarations: no logic, no latency.
// No flow control lives here; see lu_update_cell for handshakes.
package lu_pkg;

    // Default element width and number of products per element.
    localparam int SZ_DEF     = 8;
    localparam int NTERMS_DEF = 4;

    // Cell sequencing: wait for a_ij, fold in the products, hold the result.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Accumulator width that cannot overflow.
    // Each product needs 2*sz bits. Summing nterms of them, plus the sign-extended
    // a_ij, needs clog2(nterms) + 1 extra bits of headroom.
    function automatic int acc_w(input int sz, input int nterms);
        return 2 * sz + $clog2(nterms) + 1;
    endfunction

endpackage

// File: rtl/lu_update_cell_if.sv
// Bundles the element, product-term, pass-through and result ports of the cell.
// Wires only, zero latency.
// a_valid/a_ready and r_valid/r_ready are valid-ready pairs; zu_valid has no back-channel.
interface lu_update_cell_if
    import lu_pkg::*;
#(
    parameter int SZ = SZ_DEF
);
    logic signed [SZ-1:0] a_in;
    logic                 a_valid;
    logic                 a_ready;
    logic signed [SZ-1:0] z_in;
    logic signed [SZ-1:0] u_in;
    logic                 zu_valid;
    logic        [SZ-1:0] x_in;
    logic        [SZ-1:0] x_out;
    logic signed [SZ-1:0] r_out;
    logic                 r_valid;
    logic                 r_ready;
    logic                 r_sat;

    // Upstream/downstream side: feeds operands, consumes results.
    modport master (
        output a_in, a_valid, z_in, u_in, zu_valid, x_in, r_ready,
        input  a_ready, x_out, r_out, r_valid, r_sat
    );

    // Cell side.
    modport slave (
        input  a_in, a_valid, z_in, u_in, zu_valid, x_in, r_ready,
        output a_ready, x_out, r_out, r_valid, r_sat
    );

endinterface

// File: rtl/lu_mul.sv
// Signed SZ x SZ multiplier with a full 2*SZ-bit product.
// Combinational, zero latency.
// No flow control; the caller qualifies the operands.
module lu_mul
    import lu_pkg::*;
#(
    parameter int SZ = SZ_DEF
) (
    input  logic signed [SZ-1:0]   a,
    input  logic signed [SZ-1:0]   b,
    output logic signed [2*SZ-1:0] p
);
    localparam int PW = 2 * SZ;

    // Widen both signed operands before multiplying.
    // This keeps the full product, including the -2^(SZ-1) * -2^(SZ-1) corner case.
    assign p = PW'(a) * PW'(b);

endmodule

// File: rtl/lu_update_cell.sv
// LU trailing update: r = a_ij + sum over NTERMS of (z_k * u_k); optional clamp under LU_UPD_SAT_EN.
// Latency: r_valid rises NTERMS+1 cycles after a_in is accepted, plus one cycle per zu_valid bubble.
// Backpressure: result held stable while r_ready=0; a_ready only in IDLE; x_out is an unconditional 1-cycle delay.
module lu_update_cell
    import lu_pkg::*;
#(
    parameter int SZ     = SZ_DEF,
    parameter int NTERMS = NTERMS_DEF
) (
    input  logic             clk,
    input  logic             rst,
    lu_update_cell_if.slave  io
);
    localparam int ACC_W = acc_w(SZ, NTERMS);
    // Sized so the counter can reach NTERMS-1 for any NTERMS >= 1.
    localparam int CNT_W = $clog2(NTERMS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NTERMS - 1);

    state_t state;
    state_t state_nxt;

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_sum;
    logic signed [ACC_W-1:0] a_ext;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [2*SZ-1:0]  prod;
    logic        [CNT_W-1:0] cnt;

    logic                    load_a;
    logic                    take_term;
    logic                    last_term;
    logic                    deliver;

    logic signed [SZ-1:0]    res;
    logic                    res_sat;

    // The product of the current z/u pair feeds the accumulator adder.
    lu_mul #(.SZ(SZ)) u_mul (
        .a (io.z_in),
        .b (io.u_in),
        .p (prod)
    );

    assign a_ext    = ACC_W'(io.a_in);
    assign prod_ext = ACC_W'(prod);
    assign acc_sum  = acc + prod_ext;

`ifdef LU_UPD_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (SZ - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(1 << (SZ - 1)));

    // Clamp the final sum into the signed SZ-bit range and flag the clip.
    always_comb begin
        res     = acc_sum[SZ-1:0];
        res_sat = 1'b0;
        if (acc_sum > SAT_MAX) begin
            res     = {1'b0, {(SZ-1){1'b1}}};
            res_sat = 1'b1;
        end else if (acc_sum < SAT_MIN) begin
            res     = {1'b1, {(SZ-1){1'b0}}};
            res_sat = 1'b1;
        end
    end
`else
    // Wrap-around: keep the low SZ bits of the sum; the result is never flagged.
    assign res     = acc_sum[SZ-1:0];
    assign res_sat = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic plus per-cycle strobes.
    // Inputs that do not belong to the current state are simply not looked at.
    always_comb begin
        state_nxt  = state;
        load_a     = 1'b0;
        take_term  = 1'b0;
        last_term  = 1'b0;
        deliver    = 1'b0;
        io.a_ready = 1'b0;
        case (state)
            IDLE: begin
                io.a_ready = 1'b1;
                if (io.a_valid) begin
                    load_a    = 1'b1;
                    state_nxt = ACCUM;
                end
            end
            ACCUM: begin
                if (io.zu_valid) begin
                    take_term = 1'b1;
                    if (cnt == LAST_CNT) begin
                        last_term = 1'b1;
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                if (io.r_ready) begin
                    deliver   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Accumulator and term counter.
    // The result is latched on the final term, so r_out/r_sat cannot move while DONE waits.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc        <= '0;
            cnt        <= '0;
            io.r_out   <= '0;
            io.r_sat   <= 1'b0;
            io.r_valid <= 1'b0;
        end else begin
            if (load_a) begin
                acc <= a_ext;
                cnt <= '0;
            end else if (take_term) begin
                acc <= acc_sum;
                cnt <= cnt + CNT_W'(1);
            end

            if (last_term) begin
                io.r_out   <= res;
                io.r_sat   <= res_sat;
                io.r_valid <= 1'b1;
            end else if (deliver) begin
                io.r_valid <= 1'b0;
            end
        end
    end

    // Systolic pass-through: a plain one-register delay, independent of the FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            io.x_out <= '0;
        end else begin
            io.x_out <= io.x_in;
        end
    end

endmodule

// File: tb/tb_lu_update_cell.sv
// Randomised scoreboard bench for lu_update_cell (SZ=8, NTERMS=2).
// Expected results come from integer arithmetic on a_ij and the product terms.
// A monitor checks each presented result against the head of the expectation queue.
module tb_lu_update_cell;
    localparam int SZ = 8;
    localparam int NT = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lu_update_cell_if #(.SZ(SZ)) bus ();

    lu_update_cell #(.SZ(SZ), .NTERMS(NT)) dut (
        .clk (clk),
        .rst (rst),
        .io  (bus.slave)
    );

    typedef struct {
        logic signed [7:0] r;
        logic              s;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic int rs8();
        return int'($urandom_range(0, 255)) - 128;
    endfunction

    // Reference: integer sum, then wrap or clamp to 8 bits.
    function automatic exp_t model(input int a, input int z0, input int u0,
                                   input int z1, input int u1);
        exp_t e;
        int   acc;
        acc = a + z0 * u0 + z1 * u1;
`ifdef LU_UPD_SAT_EN
        if (acc > 127) begin
            e.r = 8'sd127;
            e.s = 1'b1;
        end else if (acc < -128) begin
            e.r = -8'sd128;
            e.s = 1'b1;
        end else begin
            e.r = 8'(acc);
            e.s = 1'b0;
        end
`else
        e.r = 8'(acc);
        e.s = 1'b0;
`endif
        return e;
    endfunction

    // Result monitor: compares on every cycle r_valid is high, so held data is checked too.
    always @(negedge clk) begin
        if (!rst && bus.r_valid) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_r_valid actual=1 required=0");
            end else begin
                chk("r_out", int'(bus.r_out), int'(expq[0].r));
                chk("r_sat", int'(bus.r_sat), int'(expq[0].s));
                if (bus.r_ready) void'(expq.pop_front());
            end
        end
    end

    // Pass-through monitor: x_out must equal the x_in seen at the previous edge.
    logic [7:0] x_prev;
    logic       rst_prev;
    bit         x_seen = 1'b0;
    always @(posedge clk) begin
        x_prev   = bus.x_in;
        rst_prev = rst;
        x_seen   = 1'b1;
    end
    always @(negedge clk) begin
        if (x_seen) chk("x_out", int'(bus.x_out), rst_prev ? 0 : int'(x_prev));
    end

    // Pass-through stimulus: 0x01, 0x02, 0x03 right after reset, then random.
    initial begin
        bus.x_in = 8'h55;
        wait (rst == 1'b0);
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            #1 bus.x_in = 8'(k);
        end
        forever begin
            @(posedge clk);
            #1 bus.x_in = 8'($urandom_range(0, 255));
        end
    end

    // One element update with optional bubbles between the terms and optional r_ready hold-off.
    task automatic run_op(input int a, input int z0, input int u0, input int z1,
                          input int u1, input int bub, input int hold);
        int t_acc;
        int lat;
        bit seen;
        @(posedge clk);
        #1;
        bus.a_in     = 8'(a);
        bus.a_valid  = 1'b1;
        bus.zu_valid = 1'b1;
        bus.z_in     = 8'(rs8());
        bus.u_in     = 8'(rs8());
        bus.r_ready  = (hold == 0);
        @(negedge clk);
        chk("a_ready_idle", int'(bus.a_ready), 1);
        expq.push_back(model(a, z0, u0, z1, u1));
        @(posedge clk);
        #1;
        t_acc        = cyc;
        bus.a_valid  = 1'b0;
        bus.a_in     = 8'(rs8());
        bus.zu_valid = 1'b1;
        bus.z_in     = 8'(z0);
        bus.u_in     = 8'(u0);
        @(posedge clk);
        #1;
        for (int i = 0; i < bub; i++) begin
            bus.zu_valid = 1'b0;
            bus.z_in     = 8'(rs8());
            bus.u_in     = 8'(rs8());
            @(posedge clk);
            #1;
        end
        bus.zu_valid = 1'b1;
        bus.z_in     = 8'(z1);
        bus.u_in     = 8'(u1);
        @(posedge clk);
        #1;
        bus.zu_valid = 1'b1;
        bus.z_in     = 8'(rs8());
        bus.u_in     = 8'(rs8());
        seen = 1'b0;
        lat  = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bus.r_valid) begin
                seen = 1'b1;
                lat  = cyc - t_acc + 1;
            end
        end
        bus.zu_valid = 1'b0;
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL r_valid_timeout actual=0 required=1");
        end else begin
            chk("latency", lat, NT + 1 + bub);
        end
        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                @(posedge clk);
                #1;
                bus.a_valid = (i == 1);
                bus.a_in    = 8'(rs8());
                @(negedge clk);
                chk("a_ready_done", int'(bus.a_ready), 0);
            end
            @(posedge clk);
            #1;
            bus.a_valid = 1'b0;
            bus.r_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("r_valid_drop", int'(bus.r_valid), 0);
        chk("a_ready_back", int'(bus.a_ready), 1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.a_in     = '0;
        bus.a_valid  = 1'b0;
        bus.z_in     = '0;
        bus.u_in     = '0;
        bus.zu_valid = 1'b0;
        bus.r_ready  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_r_valid", int'(bus.r_valid), 0);
        chk("rst_r_out", int'(bus.r_out), 0);
        chk("rst_r_sat", int'(bus.r_sat), 0);
        chk("rst_a_ready", int'(bus.a_ready), 1);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("a_ready_after_reset", int'(bus.a_ready), 1);

        // Basic update, backpressure, overflow and bubbles.
        run_op(10, -3, 4, -2, 5, 0, 0);
        run_op(10, -3, 4, -2, 5, 0, 5);
        run_op(100, -128, -128, 0, 0, 0, 0);
        run_op(10, -3, 4, -2, 5, 3, 0);

        // Reset after the first term throws the partial result away.
        @(posedge clk);
        #1;
        bus.a_in    = 8'sd5;
        bus.a_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.a_valid  = 1'b0;
        bus.zu_valid = 1'b1;
        bus.z_in     = 8'sd2;
        bus.u_in     = 8'sd3;
        @(posedge clk);
        #1;
        bus.zu_valid = 1'b0;
        rst          = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_r_valid", int'(bus.r_valid), 0);
        chk("rst_mid_a_ready", int'(bus.a_ready), 1);
        repeat (3) @(posedge clk);
        run_op(1, 1, 1, 1, 1, 0, 0);

        // Randomised updates with random bubbles and hold-off.
        for (int n = 0; n < 40; n++) begin
            run_op(rs8(), rs8(), rs8(), rs8(), rs8(),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("scoreboard_empty", expq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lu_update_cell.md
LU_UPDATE_CELL -- requirements
Module: lu_update_cell

Interface
REQ-001 Parameter: SZ, default 8, data width of every element port.
REQ-002 Parameter: NTERMS, default 4, products accumulated per element; legal values are NTERMS >= 1.
REQ-003 Clocking and reset: one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 a_in  in  SZ  signed initial matrix element a_ij.
REQ-007 a_valid  in  1  a_in offered.
REQ-008 a_ready  out  1  cell can accept a_in; high only in IDLE.
REQ-009 z_in  in  SZ  signed negated multiplier -l_ik, taken from the upstream negation cell zOut.
REQ-010 u_in  in  SZ  signed u_kj term.
REQ-011 zu_valid  in  1  z_in/u_in pair valid this cycle.
REQ-012 x_in  in  SZ  systolic pass-through data.
REQ-013 x_out  out  SZ  x_in delayed by one register.
REQ-014 r_out  out  SZ  updated element.
REQ-015 r_valid  out  1  r_out valid.
REQ-016 r_ready  in  1  consumer accepts r_out.
REQ-017 r_sat  out  1  result was clamped; constant 0 when saturation is compiled out.

Function
REQ-018 States: IDLE, ACCUM, DONE.
REQ-019 IDLE with a_valid=1: acc loads sign-extended a_in, cnt loads 0, next state ACCUM.
REQ-020 ACCUM with zu_valid=1: acc <= acc + signed(z_in)*signed(u_in), and cnt increments.
REQ-021 ACCUM with zu_valid=0: bubble; acc and cnt hold.
REQ-022 ACCUM with zu_valid=1 and cnt==NTERMS-1: next state DONE.
REQ-023 Accumulator width: ACC_W = 2*SZ + clog2(NTERMS) + 1, two's complement, no internal overflow.
REQ-024 DONE: r_valid=1, and r_out/r_sat are registered values.
REQ-025 In DONE, r_out and r_sat SHALL be stable while r_ready=0.
REQ-026 DONE with r_ready=1: handshake completes and next state is IDLE; r_valid falls the following cycle.
REQ-027 Latency: a_in accepted at cycle T; with no bubbles, r_valid is high at cycle T+NTERMS+1.
REQ-028 zu_valid is ignored in IDLE and DONE; a_valid is ignored outside IDLE.
REQ-029 r_ready is ignored when r_valid=0.
REQ-030 x_out <= x_in every cycle, independent of state and handshakes.

Reset
REQ-031 While rst=1 at a clock edge, the following SHALL clear: state to IDLE, acc to 0, cnt to 0, x_out to 0, r_out to 0, r_valid to 0, r_sat to 0.
REQ-032 a_ready SHALL be 1 from the first cycle after reset is released.
REQ-033 Reset mid-ACCUM or mid-DONE SHALL discard the partial result with no output.

Configuration
REQ-034 Macro LU_UPD_SAT_EN defined: r_out clamps acc to [-2^(SZ-1), 2^(SZ-1)-1], and r_sat=1 when clamped.
REQ-035 Macro LU_UPD_SAT_EN undefined: r_out = acc[SZ-1:0] (wrap-around), and r_sat is tied to 0.

Structure
REQ-036 Shared package lu_pkg SHALL hold: the state typedef (IDLE/ACCUM/DONE), the default SZ constant, and an ACC_W width function.
REQ-037 One sub-module, lu_mul, SHALL provide a combinational signed SZxSZ multiplier producing a 2*SZ product; everything else is flat.

Verification (SZ=8, NTERMS=2)
REQ-038 Basic update: a=10, then terms (-3,4) and (-2,5) back to back -> r_out=0xF4 (-12), r_valid at T+3.
REQ-039 Backpressure: scenario REQ-038 with r_ready=0 for 5 cycles -> r_out held at 0xF4 and a_ready=0. A concurrent a_valid pulse is ignored. After r_ready=1, r_valid drops the next cycle.
REQ-040 Overflow: a=100, terms (-128,-128) and (0,0) -> without macro r_out=0x64 and r_sat=0; with LU_UPD_SAT_EN, r_out=0x7F and r_sat=1.
REQ-041 Bubbles: scenario REQ-038 with zu_valid=0 for 3 cycles between the two terms -> r_out=0xF4, r_valid at T+6.
REQ-042 Reset mid-operation: rst pulsed after the first term -> next cycle r_valid=0 and a_ready=1. A fresh a=1, (1,1), (1,1) then gives r_out=0x03.
REQ-043 Pass-through: x_in=0x01,0x02,0x03 on consecutive cycles -> x_out=0x01,0x02,0x03 one cycle later, in every state.
